egress_pop_arbiter: RTL and testbench
=====================================

EGRESS_POP_ARBITER -- requirements
Module: egress_pop_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 6, data word width matching the D0/D1 FIFO outputs.
REQ-002 SHALL have parameter CNT_W, default 5, width of per-destination delivered-word counters.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port D0_empty  input  1  D0 FIFO empty flag.
REQ-006 SHALL have port D1_empty  input  1  D1 FIFO empty flag.
REQ-007 SHALL have port data_out0  input  DATA_W  D0 FIFO read data, valid the cycle after pop_D0.
REQ-008 SHALL have port data_out1  input  DATA_W  D1 FIFO read data, valid the cycle after pop_D1.
REQ-009 SHALL have port sink_ready  input  1  downstream can accept a word this cycle.
REQ-010 SHALL have port pop_D0  output  1  registered read strobe to D0 FIFO.
REQ-011 SHALL have port pop_D1  output  1  registered read strobe to D1 FIFO.
REQ-012 SHALL have port data_egress  output  DATA_W  merged output word.
REQ-013 SHALL have port valid_egress  output  1  data_egress/dest_egress valid.
REQ-014 SHALL have port dest_egress  output  1  source of current word: 0 = D0, 1 = D1.
REQ-015 SHALL have port count_D0  output  CNT_W  words delivered from D0, saturating.
REQ-016 SHALL have port count_D1  output  CNT_W  words delivered from D1, saturating.

Function
REQ-017 SHALL implement FSM states IDLE, POP, CAPTURE, HOLD.
REQ-018 IDLE: if sink_ready=1 and at least one FIFO non-empty, select a source and go to POP; else stay IDLE.
REQ-019 Selection SHALL be round-robin: grant the source other than last_served when both non-empty; grant the only non-empty one otherwise.
REQ-020 POP: exactly one of pop_D0/pop_D1 high for exactly one cycle, matching the selected source; go to CAPTURE.
REQ-021 CAPTURE: register selected data_outX into data_egress, set dest_egress, valid_egress=1, update last_served; go to HOLD.
REQ-022 HOLD: transfer occurs when valid_egress=1 and sink_ready=1; on transfer clear valid_egress, increment the matching counter, go to IDLE.
REQ-023 While valid_egress=1 and sink_ready=0, data_egress, dest_egress and valid_egress SHALL stay stable.
REQ-024 pop_D0 and pop_D1 SHALL never be high together and never high while the selected FIFO's empty flag was 1 at grant time.
REQ-025 Latency: grant in IDLE at edge N -> pop high cycle N+1 -> valid_egress high from cycle N+3; peak throughput one word per 4 cycles with sink_ready held high.
REQ-026 Counters SHALL saturate at 2^CNT_W-1 (31) and not wrap.
REQ-027 sink_ready falling during POP or CAPTURE SHALL not cancel the pop; the word is captured and held in HOLD.

Reset
REQ-028 With reset=0 at a rising edge: state=IDLE, pop_D0=pop_D1=0, data_egress=0, valid_egress=0, dest_egress=0, count_D0=count_D1=0, last_served=1 (D0 wins first).
REQ-029 Reset asserted mid-operation SHALL abort on that edge; an in-flight or held word is dropped and not counted.

Structure
REQ-030 FSM state encoding and DATA_W/CNT_W defaults SHALL live in the shared interconnect package used by the FIFO and flow-control blocks.
REQ-031 The round-robin selector SHALL be a sub-module rr_select2 (inputs two requests and last_served, outputs grant_valid and grant_id).

Verification
REQ-032 Reset 6 cycles low, release: all outputs 0, no pop while D0_empty=D1_empty=1.
REQ-033 D0 holds 1,2,3, D1 empty, sink_ready=1: pop_D0 pulses 3 times, data_egress 1,2,3 with dest 0, count_D0=3.
REQ-034 Both FIFOs hold 4 words, sink_ready=1: sources alternate D0,D1,D0,... starting D0; count_D0=count_D1=4.
REQ-035 Word 0x2A captured, sink_ready low 5 cycles: data_egress=0x2A and valid_egress=1 held stable, no further pops, single transfer when sink_ready returns.
REQ-036 40 words from D0 continuously: count_D0 stops at 31.
REQ-037 Reset asserted in HOLD: next cycle valid_egress=0, counters 0, held word never transferred.

Source files
------------

// File: rtl/egress_pop_arbiter_pkg.sv
// Shared interconnect definitions: egress FSM encoding and default data/counter widths
// used by the FIFO, flow-control and egress blocks.
package egress_pop_arbiter_pkg;

    localparam int DEF_DATA_W = 6;
    localparam int DEF_CNT_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_POP     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } egress_state_t;

endpackage

// File: rtl/egress_pop_arbiter_rr_select2.sv
// Two-way round-robin selector: when both sources request, the one not served last wins.
module rr_select2 (
    input  logic req0,
    input  logic req1,
    input  logic last_served,
    output logic grant_valid,
    output logic grant_id
);

    assign grant_valid = req0 | req1;
    assign grant_id    = (req0 && req1) ? ~last_served : req1;

endmodule

// File: rtl/egress_pop_arbiter.sv
// Merges the D0/D1 FIFO read ports into one egress stream, popping one word at a time
// and holding it until the sink accepts it; keeps saturating per-source delivery counts.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | wait for sink_ready and a non-empty FIFO, latch the grant
// ST_POP     | read strobe to the granted FIFO is high for this one cycle
// ST_CAPTURE | FIFO read data is valid; register it and raise valid_egress
// ST_HOLD    | word presented until sink_ready, then count it and go idle
module egress_pop_arbiter
    import egress_pop_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              D0_empty,
    input  logic              D1_empty,
    input  logic [DATA_W-1:0] data_out0,
    input  logic [DATA_W-1:0] data_out1,
    input  logic              sink_ready,
    output logic              pop_D0,
    output logic              pop_D1,
    output logic [DATA_W-1:0] data_egress,
    output logic              valid_egress,
    output logic              dest_egress,
    output logic [CNT_W-1:0]  count_D0,
    output logic [CNT_W-1:0]  count_D1
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    egress_state_t state;
    logic          sel_id;
    logic          last_served;
    logic          req0;
    logic          req1;
    logic          grant_valid;
    logic          grant_id;

    assign req0 = ~D0_empty;
    assign req1 = ~D1_empty;

    rr_select2 u_rr_select2 (
        .req0        (req0),
        .req1        (req1),
        .last_served (last_served),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            sel_id       <= 1'b0;
            last_served  <= 1'b1;
            pop_D0       <= 1'b0;
            pop_D1       <= 1'b0;
            data_egress  <= '0;
            valid_egress <= 1'b0;
            dest_egress  <= 1'b0;
            count_D0     <= '0;
            count_D1     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sink_ready && grant_valid) begin
                        sel_id <= grant_id;
                        pop_D0 <= ~grant_id;
                        pop_D1 <= grant_id;
                        state  <= ST_POP;
                    end
                end
                // sink_ready is deliberately ignored here and in CAPTURE: the pop is committed.
                ST_POP: begin
                    pop_D0 <= 1'b0;
                    pop_D1 <= 1'b0;
                    state  <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    data_egress  <= sel_id ? data_out1 : data_out0;
                    dest_egress  <= sel_id;
                    valid_egress <= 1'b1;
                    last_served  <= sel_id;
                    state        <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (sink_ready) begin
                        valid_egress <= 1'b0;
                        if (sel_id) begin
                            if (count_D1 != CNT_MAX) count_D1 <= count_D1 + 1'b1;
                        end else begin
                            if (count_D0 != CNT_MAX) count_D0 <= count_D0 + 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    pop_D0 <= 1'b0;
                    pop_D1 <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_egress_pop_arbiter.sv
// Directed bench for egress_pop_arbiter with behavioural D0/D1 FIFOs feeding it.
module tb_egress_pop_arbiter;

    localparam int DW = 6;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          D0_empty;
    logic          D1_empty;
    logic [DW-1:0] data_out0 = '0;
    logic [DW-1:0] data_out1 = '0;
    logic          sink_ready = 1'b0;
    logic          pop_D0;
    logic          pop_D1;
    logic [DW-1:0] data_egress;
    logic          valid_egress;
    logic          dest_egress;
    logic [CW-1:0] count_D0;
    logic [CW-1:0] count_D1;

    int n_cmp = 0;
    int n_err = 0;

    egress_pop_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .D0_empty     (D0_empty),
        .D1_empty     (D1_empty),
        .data_out0    (data_out0),
        .data_out1    (data_out1),
        .sink_ready   (sink_ready),
        .pop_D0       (pop_D0),
        .pop_D1       (pop_D1),
        .data_egress  (data_egress),
        .valid_egress (valid_egress),
        .dest_egress  (dest_egress),
        .count_D0     (count_D0),
        .count_D1     (count_D1)
    );

    always #5 clk = ~clk;

    // FIFO models: read data appears the cycle after the pop strobe.
    logic [DW-1:0] mem0 [0:127];
    logic [DW-1:0] mem1 [0:127];
    int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;

    assign D0_empty = (rd0 == wr0);
    assign D1_empty = (rd1 == wr1);

    always @(posedge clk) begin
        if (pop_D0 && rd0 != wr0) begin
            data_out0 <= mem0[rd0];
            rd0 <= rd0 + 1;
        end
        if (pop_D1 && rd1 != wr1) begin
            data_out1 <= mem1[rd1];
            rd1 <= rd1 + 1;
        end
    end

    // Transfer log and pop statistics, sampled on the edge where they take effect.
    logic [DW-1:0] log_data [0:255];
    logic          log_dest [0:255];
    int log_n = 0;
    int p0_cnt = 0, p1_cnt = 0;
    logic both_seen = 1'b0;

    always @(posedge clk) begin
        if (reset && valid_egress && sink_ready && log_n < 256) begin
            log_data[log_n] = data_egress;
            log_dest[log_n] = dest_egress;
            log_n = log_n + 1;
        end
        if (pop_D0) p0_cnt = p0_cnt + 1;
        if (pop_D1) p1_cnt = p1_cnt + 1;
        if (pop_D0 && pop_D1) both_seen = 1'b1;
    end

    task automatic push0(input logic [DW-1:0] v);
        mem0[wr0] = v;
        wr0 = wr0 + 1;
    endtask

    task automatic push1(input logic [DW-1:0] v);
        mem1[wr1] = v;
        wr1 = wr1 + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        int b0, b1;
        @(negedge clk);
        reset = 1'b0;
        sink_ready = 1'b1;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        b0 = p0_cnt;
        b1 = p1_cnt;
        repeat (5) @(negedge clk);
        n_cmp++; if (pop_D0 !== 1'b0) begin n_err++; $display("FAIL reset_pop_D0: got %b want 0", pop_D0); end
        n_cmp++; if (pop_D1 !== 1'b0) begin n_err++; $display("FAIL reset_pop_D1: got %b want 0", pop_D1); end
        n_cmp++; if (data_egress !== 6'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", data_egress); end
        n_cmp++; if (valid_egress !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_egress); end
        n_cmp++; if (dest_egress !== 1'b0) begin n_err++; $display("FAIL reset_dest: got %b want 0", dest_egress); end
        n_cmp++; if (count_D0 !== 5'd0) begin n_err++; $display("FAIL reset_count_D0: got %0d want 0", count_D0); end
        n_cmp++; if (count_D1 !== 5'd0) begin n_err++; $display("FAIL reset_count_D1: got %0d want 0", count_D1); end
        n_cmp++; if ((p0_cnt - b0) + (p1_cnt - b1) != 0) begin n_err++; $display("FAIL reset_no_pop: got %0d pops want 0", (p0_cnt - b0) + (p1_cnt - b1)); end
    endtask

    task automatic test_single_source();
        int base, b0, t;
        logic [DW-1:0] exp_d;
        base = log_n;
        b0 = p0_cnt;
        @(negedge clk);
        sink_ready = 1'b1;
        push0(6'd1); push0(6'd2); push0(6'd3);
        t = 0;
        while (pop_D0 !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        n_cmp++; if (pop_D0 !== 1'b1) begin n_err++; $display("FAIL single_first_pop: got %b want 1", pop_D0); end
        @(negedge clk);
        n_cmp++; if (valid_egress !== 1'b0) begin n_err++; $display("FAIL single_latency_early: got valid %b want 0", valid_egress); end
        @(negedge clk);
        n_cmp++; if (valid_egress !== 1'b1 || data_egress !== 6'd1) begin n_err++; $display("FAIL single_latency_valid: got valid %b data %h want 1/01", valid_egress, data_egress); end
        t = 0;
        while (log_n - base < 3 && t < 40) begin @(negedge clk); t++; end
        n_cmp++; if (log_n - base != 3) begin n_err++; $display("FAIL single_transfers: got %0d want 3", log_n - base); end
        for (int i = 0; i < 3; i++) begin
            exp_d = DW'(i + 1);
            n_cmp++; if (log_data[base + i] !== exp_d || log_dest[base + i] !== 1'b0) begin n_err++; $display("FAIL single_word%0d: got %h/%b want %h/0", i, log_data[base + i], log_dest[base + i], exp_d); end
        end
        repeat (4) @(negedge clk);
        n_cmp++; if (p0_cnt - b0 != 3) begin n_err++; $display("FAIL single_pop_count: got %0d want 3", p0_cnt - b0); end
        n_cmp++; if (count_D0 !== 5'd3) begin n_err++; $display("FAIL single_count_D0: got %0d want 3", count_D0); end
    endtask

    task automatic test_alternate();
        int base, t;
        logic [DW-1:0] exp_d;
        logic exp_s;
        do_reset();
        base = log_n;
        sink_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push0(DW'(6'h10 + i));
            push1(DW'(6'h20 + i));
        end
        t = 0;
        while (log_n - base < 8 && t < 80) begin @(negedge clk); t++; end
        n_cmp++; if (log_n - base != 8) begin n_err++; $display("FAIL alt_transfers: got %0d want 8", log_n - base); end
        for (int i = 0; i < 8; i++) begin
            exp_s = (i % 2 == 1);
            exp_d = DW'((exp_s ? 6'h20 : 6'h10) + i / 2);
            n_cmp++; if (log_data[base + i] !== exp_d || log_dest[base + i] !== exp_s) begin n_err++; $display("FAIL alt_word%0d: got %h/%b want %h/%b", i, log_data[base + i], log_dest[base + i], exp_d, exp_s); end
        end
        repeat (2) @(negedge clk);
        n_cmp++; if (count_D0 !== 5'd4) begin n_err++; $display("FAIL alt_count_D0: got %0d want 4", count_D0); end
        n_cmp++; if (count_D1 !== 5'd4) begin n_err++; $display("FAIL alt_count_D1: got %0d want 4", count_D1); end
    endtask

    task automatic test_backpressure();
        int base, b0, t;
        do_reset();
        sink_ready = 1'b0;
        base = log_n;
        b0 = p0_cnt;
        push0(6'h2A);
        push0(6'h05);
        repeat (3) @(negedge clk);
        n_cmp++; if (p0_cnt - b0 != 0) begin n_err++; $display("FAIL bp_no_pop_when_not_ready: got %0d want 0", p0_cnt - b0); end
        sink_ready = 1'b1;
        t = 0;
        while (pop_D0 !== 1'b1 && t < 10) begin @(negedge clk); t++; end
        // Drop sink_ready while the pop is in flight; the word must still be captured.
        sink_ready = 1'b0;
        t = 0;
        while (valid_egress !== 1'b1 && t < 10) begin @(negedge clk); t++; end
        n_cmp++; if (valid_egress !== 1'b1) begin n_err++; $display("FAIL bp_captured: got valid %b want 1", valid_egress); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (data_egress !== 6'h2A || valid_egress !== 1'b1 || dest_egress !== 1'b0) begin n_err++; $display("FAIL bp_hold%0d: got %h/%b/%b want 2a/1/0", i, data_egress, valid_egress, dest_egress); end
        end
        n_cmp++; if (p0_cnt - b0 != 1) begin n_err++; $display("FAIL bp_pops_during_hold: got %0d want 1", p0_cnt - b0); end
        n_cmp++; if (log_n - base != 0) begin n_err++; $display("FAIL bp_no_transfer_yet: got %0d want 0", log_n - base); end
        sink_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (log_n - base != 1 || valid_egress !== 1'b0) begin n_err++; $display("FAIL bp_single_transfer: got %0d/%b want 1/0", log_n - base, valid_egress); end
        t = 0;
        while (log_n - base < 2 && t < 20) begin @(negedge clk); t++; end
        n_cmp++; if (log_n - base != 2 || log_data[base] !== 6'h2A || log_data[base + 1] !== 6'h05) begin n_err++; $display("FAIL bp_sequence: got n=%0d %h %h want 2 2a 05", log_n - base, log_data[base], log_data[base + 1]); end
    endtask

    task automatic test_saturation();
        int base, t;
        do_reset();
        sink_ready = 1'b1;
        base = log_n;
        for (int i = 0; i < 40; i++) push0(DW'(i));
        t = 0;
        while (log_n - base < 31 && t < 200) begin @(negedge clk); t++; end
        @(negedge clk);
        n_cmp++; if (count_D0 !== 5'd31) begin n_err++; $display("FAIL sat_reach31: got %0d want 31", count_D0); end
        t = 0;
        while (log_n - base < 40 && t < 100) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        n_cmp++; if (log_n - base != 40) begin n_err++; $display("FAIL sat_transfers: got %0d want 40", log_n - base); end
        n_cmp++; if (count_D0 !== 5'd31) begin n_err++; $display("FAIL sat_count_D0: got %0d want 31", count_D0); end
        n_cmp++; if (count_D1 !== 5'd0) begin n_err++; $display("FAIL sat_count_D1: got %0d want 0", count_D1); end
    endtask

    task automatic test_reset_in_hold();
        int base, t;
        @(negedge clk);
        sink_ready = 1'b1;
        push1(6'h15);
        t = 0;
        while (pop_D1 !== 1'b1 && t < 10) begin @(negedge clk); t++; end
        sink_ready = 1'b0;
        t = 0;
        while (valid_egress !== 1'b1 && t < 10) begin @(negedge clk); t++; end
        n_cmp++; if (valid_egress !== 1'b1 || data_egress !== 6'h15 || dest_egress !== 1'b1) begin n_err++; $display("FAIL rih_held: got %b/%h/%b want 1/15/1", valid_egress, data_egress, dest_egress); end
        base = log_n;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (valid_egress !== 1'b0) begin n_err++; $display("FAIL rih_valid: got %b want 0", valid_egress); end
        n_cmp++; if (count_D0 !== 5'd0 || count_D1 !== 5'd0) begin n_err++; $display("FAIL rih_counts: got %0d/%0d want 0/0", count_D0, count_D1); end
        reset = 1'b1;
        sink_ready = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++; if (log_n - base != 0 || count_D1 !== 5'd0) begin n_err++; $display("FAIL rih_dropped: got %0d transfers count_D1 %0d want 0/0", log_n - base, count_D1); end
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_alternate();
        test_backpressure();
        test_saturation();
        test_reset_in_hold();
        n_cmp++; if (both_seen !== 1'b0) begin n_err++; $display("FAIL pops_exclusive: got %b want 0", both_seen); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
